// File: rtl/dafx_gain_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dafx_gain_ramp_scheduler
// Purpose  : Time-multiplexed gain smoother. It moves the mixer's applied
//            gains toward the register-slave targets by at most one step per
//            audio sample. A single compare/step unit visits one channel per
//            clock, and each sample tick starts one sweep over all channels.
// Revision : 1.0  initial release
// ============================================================================
module dafx_gain_ramp_scheduler #(
  parameter int N_CHANNELS_P = 5,
  parameter int GAIN_WIDTH_P = 24,
  parameter int Q_BITS_P     = 16,
  parameter int STEP_WIDTH_P = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     x_sample_tick,
  input  logic                                     cr_ramp_enable,
  input  logic [STEP_WIDTH_P-1:0]                  cr_ramp_step,
  input  logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] cr_target_gain,
  input  logic                                     cmd_clear_overrun,
  output logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] gain_out,
  output logic [N_CHANNELS_P-1:0]                  ramp_busy,
  output logic                                     sr_ramp_active,
  output logic                                     sr_tick_overrun,
  output logic                                     irq_ramp_done
);

  localparam int IDX_W = (N_CHANNELS_P > 1) ? $clog2(N_CHANNELS_P) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS_P - 1);
  localparam logic [GAIN_WIDTH_P-1:0] UNITY =
    {{(GAIN_WIDTH_P-1){1'b0}}, 1'b1} << Q_BITS_P;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                                   state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic                                     pending_q, pending_d;
  logic                                     moved_q, moved_d;
  logic                                     overrun_q, overrun_d;
  logic                                     irq_q, irq_d;
  logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] gain_q, gain_d;
  logic [N_CHANNELS_P-1:0]                  busy_q, busy_d;

  // Shared compare/step datapath for the channel in the current slot
  logic [GAIN_WIDTH_P-1:0] cur_gain, tgt_gain, new_gain;
  logic [GAIN_WIDTH_P:0]   diff, abs_diff, step_ext;
  logic                    snap, changed;

  // Signed distance to target; snap when ramping is off or the target is within one step
  always_comb begin
    cur_gain = gain_q[idx_q];
    tgt_gain = cr_target_gain[idx_q];
    diff     = {1'b0, tgt_gain} - {1'b0, cur_gain};
    abs_diff = diff[GAIN_WIDTH_P] ? -diff : diff;
    step_ext = {{(GAIN_WIDTH_P+1-STEP_WIDTH_P){1'b0}}, cr_ramp_step};
    snap     = !cr_ramp_enable || (cr_ramp_step == '0) || (abs_diff <= step_ext);
    if (snap) begin
      new_gain = tgt_gain;
    end else if (diff[GAIN_WIDTH_P]) begin
      new_gain = cur_gain - step_ext[GAIN_WIDTH_P-1:0];
    end else begin
      new_gain = cur_gain + step_ext[GAIN_WIDTH_P-1:0];
    end
    changed = (new_gain != cur_gain);
  end

  // Sweep sequencer: next-state, slot write-back, tick queueing and done flag
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    moved_d   = moved_q;
    gain_d    = gain_q;
    busy_d    = busy_q;
    irq_d     = 1'b0;
    overrun_d = overrun_q & ~cmd_clear_overrun;
    case (state_q)
      ST_IDLE: begin
        if (x_sample_tick) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
          moved_d = 1'b0;
        end
      end
      ST_UPDATE: begin
        gain_d[idx_q] = new_gain;
        busy_d[idx_q] = (new_gain != tgt_gain);
        if (changed) moved_d = 1'b1;
        // A second tick arriving while one is already queued is lost
        if (x_sample_tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          // Registered here so the pulse is visible exactly during DONE
          irq_d   = (moved_q | changed) & ~(|busy_d);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (pending_q || x_sample_tick) begin
          state_d   = ST_UPDATE;
          idx_d     = '0;
          pending_d = 1'b0;
          moved_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset returns every gain to unity immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      moved_q   <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      gain_q    <= {N_CHANNELS_P{UNITY}};
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      moved_q   <= moved_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
      gain_q    <= gain_d;
      busy_q    <= busy_d;
    end
  end

  assign gain_out        = gain_q;
  assign ramp_busy       = busy_q;
  assign sr_ramp_active  = |busy_q;
  assign sr_tick_overrun = overrun_q;
  assign irq_ramp_done   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_dafx_gain_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dafx_gain_ramp_scheduler
// Purpose  : Directed self-checking bench for the gain ramp scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_dafx_gain_ramp_scheduler;

  localparam int N  = 5;
  localparam int GW = 24;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tick;
  logic                  en;
  logic                  clr;
  logic [15:0]           step;
  logic [N-1:0][GW-1:0]  tgt;
  logic [N-1:0][GW-1:0]  gain;
  logic [N-1:0]          busy;
  logic                  active;
  logic                  ovr;
  logic                  irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dafx_gain_ramp_scheduler #(
    .N_CHANNELS_P(N),
    .GAIN_WIDTH_P(GW),
    .Q_BITS_P(16),
    .STEP_WIDTH_P(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_sample_tick(tick),
    .cr_ramp_enable(en),
    .cr_ramp_step(step),
    .cr_target_gain(tgt),
    .cmd_clear_overrun(clr),
    .gain_out(gain),
    .ramp_busy(busy),
    .sr_ramp_active(active),
    .sr_tick_overrun(ovr),
    .irq_ramp_done(irq)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One tick, then wait out the sweep while counting irq pulses
  task automatic sweep(output int irqs);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    irqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (irq) irqs++;
      @(negedge clk);
    end
  endtask

  initial begin
    int ir;
    logic [GW-1:0] e;
    logic [N-1:0][GW-1:0] oldv, newv, expv;
    logic [GW-1:0] t2 [3];
    int i2 [3];

    rst = 1'b1; tick = 1'b0; en = 1'b1; clr = 1'b0; step = 16'd4096;
    tgt = {N{24'd65536}};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_gain", gain, {N{24'd65536}});
    check("rst_busy", busy, 5'h00);
    check("rst_active", active, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_irq", irq, 1'b0);

    // 1. Ramp down channel 0 to zero in 16 steps
    tgt[0] = 24'd0;
    for (int i = 1; i <= 16; i++) begin
      sweep(ir);
      e = 24'(65536 - 4096 * i);
      check("down_gain0", gain[0], e);
      check("down_busy0", busy[0], (i < 16) ? 1'b1 : 1'b0);
      check("down_irq", ir, (i == 16) ? 1 : 0);
    end
    check("down_active", active, 1'b0);
    check("down_others", {gain[4], gain[3], gain[2], gain[1]}, {4{24'd65536}});

    // 2. Target not a multiple of the step: clamp on the last step
    tgt[4] = 24'd75536;
    t2[0] = 24'd69632; t2[1] = 24'd73728; t2[2] = 24'd75536;
    i2[0] = 0; i2[1] = 0; i2[2] = 1;
    for (int i = 0; i < 3; i++) begin
      sweep(ir);
      check("land_gain4", gain[4], t2[i]);
      check("land_irq", ir, i2[i]);
      if (i == 0) check("land_active", active, 1'b1);
    end

    // 3. Snap modes
    en = 1'b0; tgt[2] = 24'd12345;
    sweep(ir);
    check("snap_dis_gain2", gain[2], 24'd12345);
    check("snap_dis_irq", ir, 1);
    en = 1'b1; step = 16'd0; tgt[3] = 24'd777;
    sweep(ir);
    check("snap_step0_gain3", gain[3], 24'd777);
    check("snap_step0_irq", ir, 1);

    // 4. Latency and channel order
    oldv = {24'd75536, 24'd777, 24'd12345, 24'd65536, 24'd0};
    newv = {24'd5000, 24'd4000, 24'd3000, 24'd2000, 24'd1000};
    en = 1'b0; tgt = newv;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int m = 0; m < 7; m++) begin
      for (int k = 0; k < N; k++) expv[k] = (m >= k + 1) ? newv[k] : oldv[k];
      check("lat_gain", gain, expv);
      check("lat_irq", irq, (m == 5) ? 1'b1 : 1'b0);
      @(negedge clk);
    end

    // 5a. Three back-to-back ticks: one queued, one lost
    en = 1'b1; step = 16'd4096;
    @(negedge clk); tick = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk); tick = 1'b0;
    repeat (20) @(negedge clk);
    check("ovr_set", ovr, 1'b1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovr_clear", ovr, 1'b0);

    // 5b. Tick in DONE is consumed directly, so a following tick only queues
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (5) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk); tick = 1'b0;
    repeat (20) @(negedge clk);
    check("done_tick_no_ovr", ovr, 1'b0);

    // 5c. Clear coincident with a new overrun: set wins
    @(negedge clk); tick = 1'b1;
    @(negedge clk);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); tick = 1'b0; clr = 1'b0;
    repeat (20) @(negedge clk);
    check("ovr_set_wins", ovr, 1'b1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovr_clear2", ovr, 1'b0);

    // 6. Reset in the middle of a ramp sweep
    tgt = {N{24'd0}}; oldv = {N{24'd65536}}; tgt[0] = 24'd0;
    // bring every channel back to unity first via a reset
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    check("mid_pre_gain0", gain[0], 24'd61440);
    check("mid_pre_gain1", gain[1], 24'd65536);
    rst = 1'b1;
    #1;
    check("mid_rst_gain", gain, oldv);
    check("mid_rst_busy", busy, 5'h00);
    check("mid_rst_irq", irq, 1'b0);
    check("mid_rst_active", active, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_idle_gain", gain, oldv);
    sweep(ir);
    check("mid_restart_gain", gain, {N{24'd61440}});
    check("mid_restart_busy", busy, 5'h1f);
    check("mid_restart_irq", ir, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dafx_gain_ramp_scheduler.md
Name: dafx_gain_ramp_scheduler

Overview:
Time-multiplexed gain smoother between the dafx register slave and the mixer. The slave's gain registers (4 channel gains plus the output gain) are targets; this block moves the gains the mixer actually uses toward those targets by a bounded step per audio sample, which removes zipper noise. A single compare/step unit is shared by all channels. One sweep visits each channel in turn, one channel per clock, and each sweep is triggered by the sample strobe.

Parameters:
N_CHANNELS_P, 5, number of gain channels (index 0..3 = mixer channels, 4 = output gain)
GAIN_WIDTH_P, 24, unsigned gain width
Q_BITS_P, 16, fractional bits; unity = 1<<Q_BITS_P
STEP_WIDTH_P, 16, width of the ramp step register

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
x_sample_tick  in  1  one-cycle strobe per audio sample
cr_ramp_enable  in  1  1 = ramp, 0 = snap to target
cr_ramp_step  in  STEP_WIDTH_P  maximum gain change per sample (unsigned)
cr_target_gain  in  N_CHANNELS_P x GAIN_WIDTH_P  target gains from register slave
cmd_clear_overrun  in  1  one-cycle pulse; clears sr_tick_overrun
gain_out  out  N_CHANNELS_P x GAIN_WIDTH_P  gains applied by mixer (registered)
ramp_busy  out  N_CHANNELS_P  per-channel: gain_out != target at last visit (registered)
sr_ramp_active  out  1  OR of ramp_busy
sr_tick_overrun  out  1  sticky: sample tick lost
irq_ramp_done  out  1  one-cycle pulse: all channels settled

Behaviour:
- Reset values: gain_out[k] = 1<<Q_BITS_P; ramp_busy = 0; sr_tick_overrun = 0; irq_ramp_done = 0; FSM = IDLE; idx = 0; pending = 0; moved = 0.
- FSM states:
  - IDLE: x_sample_tick -> UPDATE, idx = 0, moved = 0.
  - UPDATE: one channel per cycle, with k = idx.
    - If idx == N_CHANNELS_P-1, go to DONE; otherwise idx++.
  - DONE: lasts one cycle.
    - irq_ramp_done = 1 for that cycle iff moved == 1 and every ramp_busy bit is 0.
    - If pending or x_sample_tick: go to UPDATE, idx = 0, pending = 0, moved = 0. Otherwise go to IDLE.
- Per-channel update in UPDATE slot k (cr_target_gain[k] is sampled in that cycle only; a target change mid-sweep takes effect in the channel's own slot):
  - Let d = target - gain_out[k], computed signed in GAIN_WIDTH_P+1 bits.
  - If cr_ramp_enable == 0, cr_ramp_step == 0, or |d| <= step: gain_out[k] <= target.
  - Else if d > 0: gain_out[k] += step. Else: gain_out[k] -= step.
  - Step is zero-extended to the gain width. The result never passes the target, so no overflow or wrap is possible.
  - ramp_busy[k] <= (new gain_out[k] != target).
  - moved <= 1 if gain_out[k] changed.
- Latency: a tick sampled at edge E0 gives gain_out[k] updated at edge E0+1+k. DONE is the cycle after edge E0+N_CHANNELS_P. irq_ramp_done is visible during that cycle.
- Sweep length is N_CHANNELS_P+1 cycles. The sample period must exceed this; otherwise ticks queue.
- Tick while in UPDATE:
  - pending == 0: set pending = 1.
  - pending == 1: tick lost, set sr_tick_overrun = 1.
- Tick in DONE is consumed directly and does not set pending.
- cmd_clear_overrun clears sr_tick_overrun. If it coincides with a new overrun, set wins.
- Channels not yet visited keep their value. No output changes outside a channel's UPDATE slot.
- Reset mid-sweep: all state returns to reset values at once, and all gains return to unity.
- sr_ramp_active is the combinational OR of the registered ramp_busy bits.

Test Plan:
1. Ramp down: reset, step = 4096, enable = 1, target[0] = 0, ticks every 64 cycles. gain_out[0] falls 65536 -> 61440 -> ... -> 0 over 16 ticks; ramp_busy[0] clears on tick 16; irq_ramp_done pulses exactly once, in the DONE of sweep 16; other channels stay at 65536.
2. Non-multiple landing: target[4] = 65536+10000, step = 4096. Gain goes 69632, 73728, then 75536 on tick 3 (clamped, no overshoot); irq on tick 3.
3. Snap modes: enable = 0 with target[2] = 12345 gives gain_out[2] = 12345 in one sweep. With enable = 1 and step = 0, target[3] = 777 gives 777 in one sweep; irq pulses in both cases.
4. Latency/order: all targets changed, a single tick at edge E0. gain_out[k] changes exactly at edge E0+1+k; irq is high only in the cycle after edge E0+5.
5. Overrun: ticks at E0, E0+1, E0+2. First tick sweeps; second sets pending and starts a new sweep straight from DONE; third sets sr_tick_overrun = 1. cmd_clear_overrun clears it; clear coincident with a new overrun leaves it at 1.
6. Reset mid-sweep: rst asserted at edge E0+2 during a ramp. All gain_out = 65536, ramp_busy = 0, irq = 0, and the FSM is back in IDLE. The next tick restarts cleanly from idx 0.
